// File: rtl/obstacle_sensor_frontend.sv
// rtl/obstacle_sensor_frontend.sv - per-sensor 4-sample averaging with hysteretic obstacle and lane-clear flags
// Optional feature macro: SENSOR_WATCHDOG_EN (per-sensor sample watchdog, fail-safe output forcing)
module obstacle_sensor_frontend #(
   parameter int RANGE_W           = 10,
   parameter int NEAR_THRESH       = 100,
   parameter int FAR_THRESH        = 120,
   parameter int SLOW_THRESH       = 250,
   parameter int CLOSE_DELTA       = 8,
   parameter int LANE_CLEAR_THRESH = 200,
   parameter int LANE_HOLD         = 4,
   parameter int TIMEOUT           = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [1:0]         s_sensor_id,
   input  logic [RANGE_W-1:0] s_range,
   output logic               front_obstacle_detected,
   output logic               left_obstacle_detected,
   output logic               right_obstacle_detected,
   output logic               front_obstacle_slow,
   output logic               lane_clear_left,
   output logic               lane_clear_right,
   output logic [2:0]         sensor_fault
);

   localparam int SUM_W = RANGE_W + 2;
   localparam int LC_W  = $clog2(LANE_HOLD + 1);

   localparam logic [RANGE_W-1:0] NEAR_V  = RANGE_W'(NEAR_THRESH);
   localparam logic [RANGE_W-1:0] FAR_V   = RANGE_W'(FAR_THRESH);
   localparam logic [RANGE_W-1:0] SLOW_V  = RANGE_W'(SLOW_THRESH);
   localparam logic [RANGE_W-1:0] DELTA_V = RANGE_W'(CLOSE_DELTA);
   localparam logic [RANGE_W-1:0] LANE_V  = RANGE_W'(LANE_CLEAR_THRESH);
   localparam logic [LC_W-1:0]    HOLD_V  = LC_W'(LANE_HOLD);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCUM  = 2'd1;
   localparam logic [1:0] ST_DECIDE = 2'd2;

   logic [1:0]         state_q, state_n;
   logic               ready_q;
   logic [1:0]         id_q;
   logic [RANGE_W-1:0] range_q;

   logic [RANGE_W-1:0] buf_q  [0:2][0:3];
   logic [1:0]         ptr_q  [0:2];
   logic [SUM_W-1:0]   sum_q  [0:2];
   logic [2:0]         fill_q [0:2];

   logic [2:0]         det_q, det_n;
   logic               slow_q, slow_n;
   logic [1:0]         lane_q, lane_n;
   logic [RANGE_W-1:0] prev_avg_q;
   logic [LC_W-1:0]    lane_cnt_q [0:1];
   logic [LC_W-1:0]    lane_cnt_new;

   logic [1:0]         sel;
   logic               lsel;
   logic               accum_ok, decide_ok, full;
   logic [RANGE_W-1:0] avg;
   logic [SUM_W-1:0]   sum_new;

   // Sensor selection for the latched sample; reserved id 3 is folded onto front but never acted on
   always_comb begin
      sel       = (id_q == 2'd3) ? 2'd0 : id_q;
      lsel      = (sel == 2'd2);
      accum_ok  = (state_q == ST_ACCUM)  && (id_q != 2'd3);
      decide_ok = (state_q == ST_DECIDE) && (id_q != 2'd3);
      sum_new   = sum_q[sel] - {2'b00, buf_q[sel][ptr_q[sel]]} + {2'b00, range_q};
      avg       = sum_q[sel][SUM_W-1:2];
      full      = (fill_q[sel] == 3'd4);
   end

   // Three-phase handshake sequencer: IDLE accepts, ACCUM updates averages, DECIDE updates flags
   always_comb begin
      state_n = state_q;
      case (state_q)
         ST_IDLE:   if (s_valid) state_n = ST_ACCUM;
         ST_ACCUM:  state_n = ST_DECIDE;
         ST_DECIDE: state_n = ST_IDLE;
         default:   state_n = ST_IDLE;
      endcase
   end

   // Flag decisions for the sensor in DECIDE; every other sensor's flags hold
   always_comb begin
      det_n        = det_q;
      slow_n       = slow_q;
      lane_n       = lane_q;
      lane_cnt_new = lane_cnt_q[lsel];
      if (decide_ok) begin
         if (!full)
            det_n[sel] = 1'b0;
         else if (avg < NEAR_V)
            det_n[sel] = 1'b1;
         else if (avg >= FAR_V)
            det_n[sel] = 1'b0;
         if (sel == 2'd0) begin
            slow_n = full && (prev_avg_q > avg) && ((prev_avg_q - avg) >= DELTA_V) && (avg < SLOW_V);
         end else begin
            if (full && (avg >= LANE_V))
               lane_cnt_new = (lane_cnt_q[lsel] == HOLD_V) ? HOLD_V : lane_cnt_q[lsel] + 1'b1;
            else
               lane_cnt_new = '0;
            lane_n[lsel] = (lane_cnt_new >= HOLD_V);
         end
      end
   end

   // Control registers: state, registered ready and the latched sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         id_q    <= 2'd0;
         range_q <= '0;
      end else begin
         state_q <= state_n;
         ready_q <= (state_n == ST_IDLE);
         if ((state_q == ST_IDLE) && s_valid) begin
            id_q    <= s_sensor_id;
            range_q <= s_range;
         end
      end
   end

   // Per-sensor circular buffers, running sums and fill counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 4; k++) buf_q[s][k] <= '0;
            ptr_q[s]  <= 2'd0;
            sum_q[s]  <= '0;
            fill_q[s] <= 3'd0;
         end
      end else if (accum_ok) begin
         buf_q[sel][ptr_q[sel]] <= range_q;
         sum_q[sel]             <= sum_new;
         ptr_q[sel]             <= ptr_q[sel] + 2'd1;
         if (fill_q[sel] != 3'd4) fill_q[sel] <= fill_q[sel] + 3'd1;
      end
   end

   // Flag state, front closing reference and side lane-hold counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         det_q         <= 3'b000;
         slow_q        <= 1'b0;
         lane_q        <= 2'b00;
         prev_avg_q    <= '0;
         lane_cnt_q[0] <= '0;
         lane_cnt_q[1] <= '0;
      end else begin
         det_q  <= det_n;
         slow_q <= slow_n;
         lane_q <= lane_n;
         if (decide_ok) begin
            if (sel == 2'd0)
               prev_avg_q <= avg;
            else
               lane_cnt_q[lsel] <= lane_cnt_new;
         end
      end
   end

`ifdef SENSOR_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] TIMEOUT_V = WD_W'(TIMEOUT);

   logic [WD_W-1:0] wd_q [0:2];
   logic [WD_W-1:0] wd_n [0:2];
   logic [2:0]      fault_q, fault_n;
   logic [2:0]      det_o_q;
   logic [1:0]      lane_o_q;

   // Watchdog: count idle cycles per sensor; a DECIDE for that sensor wins over a coincident expiry
   always_comb begin
      wd_n    = wd_q;
      fault_n = fault_q;
      for (int i = 0; i < 3; i++) begin
         if (decide_ok && (sel == 2'(i))) begin
            wd_n[i]    = '0;
            fault_n[i] = 1'b0;
         end else begin
            wd_n[i]    = (wd_q[i] == TIMEOUT_V) ? wd_q[i] : wd_q[i] + 1'b1;
            fault_n[i] = fault_q[i] | (wd_n[i] == TIMEOUT_V);
         end
      end
   end

   // Watchdog state and fail-safe forced output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) wd_q[i] <= '0;
         fault_q  <= 3'b000;
         det_o_q  <= 3'b000;
         lane_o_q <= 2'b00;
      end else begin
         wd_q     <= wd_n;
         fault_q  <= fault_n;
         det_o_q  <= det_n | fault_n;
         lane_o_q <= lane_n & ~fault_n[2:1];
      end
   end

   assign front_obstacle_detected = det_o_q[0];
   assign left_obstacle_detected  = det_o_q[1];
   assign right_obstacle_detected = det_o_q[2];
   assign lane_clear_left         = lane_o_q[0];
   assign lane_clear_right        = lane_o_q[1];
   assign sensor_fault            = fault_q;
`else
   assign front_obstacle_detected = det_q[0];
   assign left_obstacle_detected  = det_q[1];
   assign right_obstacle_detected = det_q[2];
   assign lane_clear_left         = lane_q[0];
   assign lane_clear_right        = lane_q[1];
   assign sensor_fault            = 3'b000;
`endif

   assign s_ready             = ready_q;
   assign front_obstacle_slow = slow_q;

endmodule

// File: tb/tb_obstacle_sensor_frontend.sv
// tb/tb_obstacle_sensor_frontend.sv - randomized and directed bench for obstacle_sensor_frontend
module tb_obstacle_sensor_frontend;

   localparam int TIMEOUT_T = 1024;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [1:0] s_sensor_id = 2'd0;
   logic [9:0] s_range = 10'd0;
   logic       front_obstacle_detected, left_obstacle_detected, right_obstacle_detected;
   logic       front_obstacle_slow, lane_clear_left, lane_clear_right;
   logic [2:0] sensor_fault;

   obstacle_sensor_frontend dut (
      .clk                     (clk),
      .rst                     (rst),
      .s_valid                 (s_valid),
      .s_ready                 (s_ready),
      .s_sensor_id             (s_sensor_id),
      .s_range                 (s_range),
      .front_obstacle_detected (front_obstacle_detected),
      .left_obstacle_detected  (left_obstacle_detected),
      .right_obstacle_detected (right_obstacle_detected),
      .front_obstacle_slow     (front_obstacle_slow),
      .lane_clear_left         (lane_clear_left),
      .lane_clear_right        (lane_clear_right),
      .sensor_fault            (sensor_fault)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // reference model: last four samples per sensor, kept as plain integers
   int last [3][4];
   int n    [3];
   int run  [2];
   int wd   [3];
   int prev_avg;
   bit m_det [3];
   bit m_slow;
   bit m_lane [2];
   int pend, pid, dec;
   bit hs, p_det, p_slow, p_lane;

   task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 3; s++) begin
         for (int k = 0; k < 4; k++) last[s][k] = 0;
         n[s] = 0; wd[s] = 0; m_det[s] = 1'b0;
      end
      run[0] = 0; run[1] = 0; m_lane[0] = 1'b0; m_lane[1] = 1'b0;
      prev_avg = 0; m_slow = 1'b0; pend = 0; pid = 3;
   endtask

   task automatic predict(input int id, input int r);
      int sum, avg;
      bit full;
      for (int k = 3; k > 0; k--) last[id][k] = last[id][k-1];
      last[id][0] = r;
      if (n[id] < 4) n[id]++;
      sum = 0;
      for (int k = 0; k < 4; k++) sum += last[id][k];
      avg  = sum / 4;
      full = (n[id] == 4);
      p_det = m_det[id];
      if (!full) p_det = 1'b0;
      else if (avg < 100) p_det = 1'b1;
      else if (avg >= 120) p_det = 1'b0;
      if (id == 0) begin
         p_slow = full && (prev_avg > avg) && (prev_avg - avg >= 8) && (avg < 250);
         prev_avg = avg;
      end else begin
         if (full && avg >= 200) begin
            if (run[id-1] < 4) run[id-1]++;
         end else begin
            run[id-1] = 0;
         end
         p_lane = (run[id-1] >= 4);
      end
   endtask

   // model steps on each clock edge, resets asynchronously with the DUT
   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            model_reset();
         end else begin
            hs  = s_valid && (pend == 0);
            dec = -1;
            if (pend > 0) begin
               pend--;
               if (pend == 0 && pid < 3) begin
                  dec = pid;
                  m_det[pid] = p_det;
                  if (pid == 0) m_slow = p_slow;
                  else m_lane[pid-1] = p_lane;
               end
            end
`ifdef SENSOR_WATCHDOG_EN
            for (int s = 0; s < 3; s++)
               wd[s] = (s == dec) ? 0 : ((wd[s] < TIMEOUT_T) ? wd[s] + 1 : wd[s]);
`endif
            if (hs) begin
               pend = 2;
               pid  = int'(s_sensor_id);
               if (pid < 3) predict(pid, int'(s_range));
            end
         end
      end
   end

   // compare every output against the model away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("s_ready", s_ready, pend == 0);
            chk("front_det", front_obstacle_detected, m_det[0] | (wd[0] >= TIMEOUT_T));
            chk("left_det",  left_obstacle_detected,  m_det[1] | (wd[1] >= TIMEOUT_T));
            chk("right_det", right_obstacle_detected, m_det[2] | (wd[2] >= TIMEOUT_T));
            chk("front_slow", front_obstacle_slow, m_slow);
            chk("lane_left",  lane_clear_left,  m_lane[0] & (wd[1] < TIMEOUT_T));
            chk("lane_right", lane_clear_right, m_lane[1] & (wd[2] < TIMEOUT_T));
            chk("sensor_fault", sensor_fault,
                {wd[2] >= TIMEOUT_T, wd[1] >= TIMEOUT_T, wd[0] >= TIMEOUT_T});
         end
      end
   end

   // present a sample and hold it until accepted; returns on the negedge after the accept edge
   task automatic send(input int id, input int r);
      int t;
      logic [1:0] idv;
      logic [9:0] rv;
      idv = 2'(id);
      rv  = 10'(r);
      t   = 0;
      @(negedge clk);
      s_valid = 1'b1; s_sensor_id = idv; s_range = rv;
      while (!s_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready) chk("send_accept_timeout", 10'd0, 10'd1);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic send_wait(input int id, input int r);
      send(id, r);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("pin_reset_ready", s_ready, 1'b1);
      chk("pin_reset_fault", sensor_fault, 3'b000);

      // four front samples of 90: flag only after the fourth, ready low for two cycles
      repeat (3) send_wait(0, 90);
      chk("pin_front_det_fill", front_obstacle_detected, 1'b0);
      send(0, 90);
      chk("pin_ready_low1", s_ready, 1'b0);
      @(negedge clk);
      chk("pin_ready_low2", s_ready, 1'b0);
      chk("pin_front_det_pre", front_obstacle_detected, 1'b0);
      @(negedge clk);
      chk("pin_ready_back", s_ready, 1'b1);
      chk("pin_front_det_set", front_obstacle_detected, 1'b1);
      chk("pin_model_det_set", m_det[0], 1'b1);

      // hysteresis band holds, far threshold clears
      repeat (4) send_wait(0, 110);
      chk("pin_front_det_hold", front_obstacle_detected, 1'b1);
      send_wait(0, 130);
      chk("pin_front_det_115", front_obstacle_detected, 1'b1);
      send_wait(0, 130);
      chk("pin_front_det_clear", front_obstacle_detected, 1'b0);
      repeat (2) send_wait(0, 130);

      // closing detection
      repeat (4) send_wait(0, 300);
      repeat (3) send_wait(0, 240);
      chk("pin_slow_255", front_obstacle_slow, 1'b0);
      send_wait(0, 240);
      chk("pin_slow_set", front_obstacle_slow, 1'b1);
      chk("pin_model_slow", m_slow, 1'b1);
      send_wait(0, 240);
      chk("pin_slow_equal", front_obstacle_slow, 1'b0);

      // lane clear hold on the left
      repeat (6) send_wait(1, 220);
      chk("pin_lane_left_6", lane_clear_left, 1'b0);
      send_wait(1, 220);
      chk("pin_lane_left_7", lane_clear_left, 1'b1);
      chk("pin_model_lane", m_lane[0], 1'b1);
      send_wait(3, 0);
      chk("pin_id3_lane", lane_clear_left, 1'b1);
      chk("pin_id3_front", front_obstacle_detected, 1'b0);
      send_wait(1, 50);
      chk("pin_lane_left_drop", lane_clear_left, 1'b0);

      // reset in the middle of a reserved-id transaction
      send(3, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("pin_rst_mid_ready", s_ready, 1'b1);
      chk("pin_rst_mid_lane", lane_clear_left, 1'b0);

      // randomized traffic, including valid held while busy and reserved ids
      repeat (3000) begin
         @(negedge clk);
         s_valid     = ($urandom_range(0, 3) != 0);
         s_sensor_id = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) s_range = 10'($urandom_range(0, 1023));
         else s_range = 10'($urandom_range(80, 280));
      end
      @(negedge clk);
      s_valid = 1'b0;
      repeat (3) @(negedge clk);

`ifdef SENSOR_WATCHDOG_EN
      // right sensor silent while front and left keep reporting
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (24) begin
         send_wait(0, 300);
         send_wait(1, 300);
         repeat (40) @(negedge clk);
      end
      chk("pin_wd_fault", sensor_fault, 3'b100);
      chk("pin_wd_right_det", right_obstacle_detected, 1'b1);
      chk("pin_wd_lane_right", lane_clear_right, 1'b0);
      send_wait(2, 500);
      chk("pin_wd_fault_clear", sensor_fault, 3'b000);
      chk("pin_wd_right_det_clear", right_obstacle_detected, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
